// File: rtl/address_builder_pkg.sv
// Shared types and widths for the address builder.
// Holds the state enum and the address/byte width constants.
package address_builder_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY,
    HAVE_LOW,
    READY,
    FIXUP
  } state_t;

endpackage

// File: rtl/address_builder_page_incrementer.sv
// page_incrementer: 8-bit adder with carry-in and carry-out.
// Ports: a, b (operands), cin, sum, cout.
module page_incrementer
  import address_builder_pkg::*;
(
  input  logic [BYTE_WIDTH-1:0] a,
  input  logic [BYTE_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [BYTE_WIDTH-1:0] sum,
  output logic                  cout
);

  logic [BYTE_WIDTH:0] total;

  assign total = {1'b0, a} + {1'b0, b}
               + {{BYTE_WIDTH{1'b0}}, cin};
  assign sum   = total[BYTE_WIDTH-1:0];
  assign cout  = total[BYTE_WIDTH];

endmodule

// File: rtl/address_builder.sv
// address_builder: builds a 16-bit address {ADH,ADL} from bus bytes,
// with indexed add, page-cross fixup and 16-bit increment.
// Ports: clk, nrst (sync active-low), busData, loadLow, loadHigh,
//   addIndex, indexValue, increment -> address, valid, busy, pageCross.
// Option: ADDRESS_BUILDER_PAGE_CROSS_EN enables the FIXUP cycle on an
//   ADL carry; without it the carry is dropped (wrap within page).
module address_builder
  import address_builder_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 16'hFFFC
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [BYTE_WIDTH-1:0] busData,
  input  logic                  loadLow,
  input  logic                  loadHigh,
  input  logic                  addIndex,
  input  logic [BYTE_WIDTH-1:0] indexValue,
  input  logic                  increment,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  valid,
  output logic                  busy,
  output logic                  pageCross
);

  state_t state, state_nx;

  logic [BYTE_WIDTH-1:0] adl, adl_nx;
  logic [BYTE_WIDTH-1:0] adh, adh_nx;
  logic                  pc_q, pc_nx;

  logic in_fixup;
  logic load_any;
  logic add_go;
  logic inc_go;

  logic [BYTE_WIDTH-1:0] lo_b, lo_sum, hi_sum;
  logic                  lo_cin, lo_cout;
  logic                  hi_cin, hi_cout;

`ifdef ADDRESS_BUILDER_PAGE_CROSS_EN
  assign in_fixup = (state == FIXUP);
`else
  assign in_fixup = 1'b0;
`endif

  // FIXUP swallows every command for its single cycle.
  assign load_any = (loadLow | loadHigh) & ~in_fixup;
  assign add_go   = ~load_any & addIndex
                  & (state == READY);
  assign inc_go   = ~load_any & ~addIndex & increment
                  & (state == READY);

  // Low adder serves both the index add and the +1.
  assign lo_b   = add_go ? indexValue : '0;
  assign lo_cin = inc_go;

  // High adder serves both the fixup and the +1 ripple.
  assign hi_cin = in_fixup | (inc_go & lo_cout);

  page_incrementer u_lo (
    .a    (adl),
    .b    (lo_b),
    .cin  (lo_cin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  page_incrementer u_hi (
    .a    (adh),
    .b    ('0),
    .cin  (hi_cin),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_comb begin
    state_nx = state;
    adl_nx   = adl;
    adh_nx   = adh;
    pc_nx    = 1'b0;
    unique case (1'b1)
      in_fixup: begin
        adh_nx   = hi_sum;
        state_nx = READY;
      end
      load_any: begin
        if (loadLow)  adl_nx = busData;
        if (loadHigh) adh_nx = busData;
        if (loadLow)
          state_nx = loadHigh ? READY : HAVE_LOW;
        else if (state != EMPTY)
          state_nx = READY;
      end
      add_go: begin
        adl_nx = lo_sum;
`ifdef ADDRESS_BUILDER_PAGE_CROSS_EN
        if (lo_cout) begin
          state_nx = FIXUP;
          pc_nx    = 1'b1;
        end
`endif
      end
      inc_go: begin
        adl_nx = lo_sum;
        adh_nx = hi_sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= EMPTY;
      adl   <= RESET_ADDR[BYTE_WIDTH-1:0];
      adh   <= RESET_ADDR[ADDR_WIDTH-1:BYTE_WIDTH];
      pc_q  <= 1'b0;
    end else begin
      state <= state_nx;
      adl   <= adl_nx;
      adh   <= adh_nx;
      pc_q  <= pc_nx;
    end
  end

  assign address = {adh, adl};
  assign valid   = (state == READY);

`ifdef ADDRESS_BUILDER_PAGE_CROSS_EN
  assign busy      = (state == FIXUP);
  assign pageCross = pc_q;
`else
  assign busy      = 1'b0;
  assign pageCross = 1'b0;
`endif

  // The high adder's carry-out is meaningless: ADH wraps FF->00.
  logic unused_ok;
  assign unused_ok = hi_cout;

endmodule

// File: tb/tb_address_builder.sv
// Testbench for address_builder: reference model plus directed
// vectors with hand-computed literal expectations.
module tb_address_builder;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  busData;
  logic        loadLow;
  logic        loadHigh;
  logic        addIndex;
  logic [7:0]  indexValue;
  logic        increment;
  logic [15:0] address;
  logic        valid;
  logic        busy;
  logic        pageCross;

  int n_checks = 0;
  int n_errors = 0;

  address_builder #(.RESET_ADDR(16'hFFFC)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .busData    (busData),
    .loadLow    (loadLow),
    .loadHigh   (loadHigh),
    .addIndex   (addIndex),
    .indexValue (indexValue),
    .increment  (increment),
    .address    (address),
    .valid      (valid),
    .busy       (busy),
    .pageCross  (pageCross)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: 0=EMPTY 1=HAVE_LOW 2=READY 3=FIXUP
  int m_addr;
  int m_st;
  int m_pc;
  bit started = 0;

`ifdef ADDRESS_BUILDER_PAGE_CROSS_EN
  localparam bit PX = 1'b1;
`else
  localparam bit PX = 1'b0;
`endif

  always @(posedge clk) begin
    int a, s, lo, hi, sum;
    a = m_addr; s = m_st;
    lo = a % 256; hi = a / 256;
    if (!nrst) begin
      m_addr <= 16'hFFFC; m_st <= 0; m_pc <= 0;
    end else if (s == 3) begin
      m_addr <= ((hi + 1) % 256) * 256 + lo;
      m_st <= 2; m_pc <= 0;
    end else if (loadLow || loadHigh) begin
      if (loadLow) lo = busData;
      if (loadHigh) hi = busData;
      m_addr <= hi * 256 + lo;
      m_st <= loadLow ? (loadHigh ? 2 : 1) : (s == 0 ? 0 : 2);
      m_pc <= 0;
    end else if (addIndex && s == 2) begin
      sum = lo + indexValue;
      m_addr <= hi * 256 + sum % 256;
      m_st <= (sum > 255 && PX) ? 3 : 2;
      m_pc <= (sum > 255 && PX) ? 1 : 0;
    end else if (increment && s == 2) begin
      m_addr <= (a + 1) % 65536;
      m_pc <= 0;
    end else begin
      m_pc <= 0;
    end
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_address", address, m_addr);
      check("model_valid", valid, m_st == 2);
      check("model_busy", busy, m_st == 3);
      check("model_pageCross", pageCross, m_pc);
    end
  end

  task automatic cyc(bit ll, bit lh, logic [7:0] bd,
                     bit ai, logic [7:0] ix, bit inc);
    loadLow = ll; loadHigh = lh; busData = bd;
    addIndex = ai; indexValue = ix; increment = inc;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic load16(logic [7:0] h, logic [7:0] l);
    cyc(1, 0, l, 0, 8'h00, 0);
    cyc(0, 1, h, 0, 8'h00, 0);
  endtask

  initial begin
    nrst = 1'b0;
    loadLow = 0; loadHigh = 0; busData = 0;
    addIndex = 0; indexValue = 0; increment = 0;
    idle(); idle();
    check("rst_address", address, 16'hFFFC);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pc", pageCross, 0);

    nrst = 1'b1;
    // Commands ignored outside READY; loadHigh keeps EMPTY.
    cyc(0, 0, 8'h00, 1, 8'h10, 1);
    check("empty_ign", address, 16'hFFFC);
    cyc(0, 1, 8'h77, 0, 8'h00, 0);
    check("empty_hi_addr", address, 16'h77FC);
    check("empty_hi_valid", valid, 0);

    cyc(1, 0, 8'h34, 0, 8'h00, 0);
    check("lo_addr", address, 16'h7734);
    check("lo_valid", valid, 0);
    cyc(0, 1, 8'h12, 0, 8'h00, 0);
    check("hi_addr", address, 16'h1234);
    check("hi_valid", valid, 1);

    // Page-crossing index add.
    load16(8'h12, 8'hF0);
    cyc(0, 0, 8'h00, 1, 8'h20, 0);
    check("idx_c1_addr", address, 16'h1210);
    check("idx_c1_pc", pageCross, PX);
    check("idx_c1_busy", busy, PX);
    idle();
    check("idx_c2_addr", address, PX ? 16'h1310 : 16'h1210);
    check("idx_c2_valid", valid, 1);
    check("idx_c2_pc", pageCross, 0);

    // Index add without carry.
    cyc(0, 0, 8'h00, 1, 8'h05, 0);
    check("idx_nc", address, PX ? 16'h1315 : 16'h1215);

    // Increment wraps.
    cyc(1, 1, 8'hFF, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    check("inc_wrap", address, 16'h0000);
    check("inc_wrap_pc", pageCross, 0);
    load16(8'h12, 8'hFF);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    check("inc_page", address, 16'h1300);

    // Load beats addIndex in the same cycle.
    cyc(1, 1, 8'hAB, 1, 8'h80, 1);
    check("prio_addr", address, 16'hABAB);
    check("prio_valid", valid, 1);

    // Commands in FIXUP are ignored.
    load16(8'h12, 8'hF0);
    cyc(0, 0, 8'h00, 1, 8'h20, 0);
    cyc(1, 1, 8'h55, 0, 8'h00, 0);
    check("fix_ign", address, PX ? 16'h1310 : 16'h5555);

    // ADH wraps FF -> 00 on fixup.
    load16(8'hFF, 8'hF0);
    cyc(0, 0, 8'h00, 1, 8'h20, 0);
    idle();
    check("fix_wrap", address, PX ? 16'h0010 : 16'hFF10);

    // Reset during FIXUP drops the pending increment.
    load16(8'h12, 8'hF0);
    cyc(0, 0, 8'h00, 1, 8'h20, 0);
    nrst = 1'b0;
    idle();
    check("rstfix_addr", address, 16'hFFFC);
    check("rstfix_valid", valid, 0);
    check("rstfix_busy", busy, 0);
    nrst = 1'b1;
    idle();
    check("rstfix_after", address, 16'hFFFC);

    // loadLow from READY drops back to HAVE_LOW.
    cyc(1, 1, 8'h44, 0, 8'h00, 0);
    cyc(1, 0, 8'h99, 0, 8'h00, 0);
    check("rl_addr", address, 16'h4499);
    check("rl_valid", valid, 0);

    idle();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/address_builder.md
ADDRESS_BUILDER -- requirements
Module: address_builder

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 16'hFFFC, the value of address after reset.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-004 SHALL have port busData  input  8  byte driven from the internal bus output.
REQ-005 SHALL have port loadLow  input  1  capture busData into the low address byte (ADL).
REQ-006 SHALL have port loadHigh  input  1  capture busData into the high address byte (ADH).
REQ-007 SHALL have port addIndex  input  1  add indexValue to ADL.
REQ-008 SHALL have port indexValue  input  8  X/Y index byte for addIndex.
REQ-009 SHALL have port increment  input  1  16-bit increment of {ADH,ADL}.
REQ-010 SHALL have port address  output  16  registered {ADH,ADL}.
REQ-011 SHALL have port valid  output  1  high when state is READY.
REQ-012 SHALL have port busy  output  1  high when state is FIXUP.
REQ-013 SHALL have port pageCross  output  1  one-cycle registered pulse on ADL carry-out.

Function
REQ-014 SHALL implement states EMPTY, HAVE_LOW, READY, FIXUP; all outputs registered or decoded from state only.
REQ-015 Command priority per cycle SHALL be: loadLow/loadHigh > addIndex > increment; lower ones ignored when a higher one is asserted.
REQ-016 loadLow in EMPTY/HAVE_LOW/READY SHALL set ADL=busData next edge; state -> HAVE_LOW, or READY if loadHigh is asserted together (ADH also set from the same busData).
REQ-017 loadHigh alone SHALL set ADH=busData; state -> READY from HAVE_LOW/READY, stays EMPTY from EMPTY.
REQ-018 addIndex in READY SHALL set ADL=(ADL+indexValue) mod 256; on carry-out state -> FIXUP and pageCross=1 for exactly one cycle; no carry -> stay READY.
REQ-019 FIXUP SHALL last exactly one cycle: ADH=(ADH+1) mod 256 (FF->00 wrap), then -> READY; all commands ignored in FIXUP.
REQ-020 increment in READY SHALL set address=(address+1) mod 65536 in one cycle (FFFF->0000), no FIXUP, pageCross stays 0.
REQ-021 addIndex and increment outside READY SHALL be ignored with no state or data change.
REQ-022 Latency: any accepted command SHALL be visible on address the cycle after the edge that samples it.

Reset
REQ-023 nrst=0 at a rising edge SHALL force state EMPTY, address=RESET_ADDR, valid=0, busy=0, pageCross=0, overriding all commands.
REQ-024 Reset asserted during FIXUP SHALL abandon the pending ADH increment.

Configuration
REQ-025 Macro ADDRESS_BUILDER_PAGE_CROSS_EN defined: behaviour per REQ-018/019.
REQ-026 Macro undefined: FIXUP state not built, ADL carry discarded (wrap within page), state stays READY, busy and pageCross tied 0.

Structure
REQ-027 Shared package SHALL hold the state enum typedef and constants ADDR_WIDTH=16, BYTE_WIDTH=8.
REQ-028 A sub-module page_incrementer (8-bit add with carry-in, carry-out) SHALL be used for both ADL add and ADH fixup.

Verification
REQ-029 Reset -> address=16'hFFFC, valid=0, busy=0, pageCross=0.
REQ-030 loadLow busData=34, then loadHigh busData=12 -> address=1234, valid=1 after second edge.
REQ-031 READY address=12F0, addIndex indexValue=20 -> cycle1 address=1210, pageCross=1, busy=1; cycle2 address=1310, valid=1 (macro defined); macro undefined -> address=1210 stays, pageCross=0.
REQ-032 READY address=FFFF, increment -> address=0000, pageCross=0; increment with address=12FF -> 1300.
REQ-033 loadLow+loadHigh+addIndex same cycle busData=AB -> address=ABAB, READY, addIndex ignored.
REQ-034 nrst=0 during FIXUP of address 12F0+20 -> address=FFFC, EMPTY, no ADH increment afterwards.
